// File: rtl/mvm_transpose.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mvm_transpose: tiled signed fixed-point matrix-vector product              |
// | result[h] = sat((sum_w matrix[h][w] * vector[w]) >>> FRACTION_WIDTH)       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mvm_transpose #(
  parameter int MATRIX_WIDTH      = 4,
  parameter int MATRIX_HEIGHT     = 5,
  parameter int VECTOR_CELL_WIDTH = 8,
  parameter int MATRIX_CELL_WIDTH = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION_WIDTH    = 4,
  parameter int TILING_ROW        = 3,
  parameter int TILING_COL        = 3
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic [MATRIX_WIDTH*VECTOR_CELL_WIDTH-1:0]                vector,
  input  logic                                                     vector_valid,
  output logic                                                     vector_ready,
  input  logic [MATRIX_WIDTH*MATRIX_HEIGHT*MATRIX_CELL_WIDTH-1:0]  matrix,
  input  logic                                                     matrix_valid,
  output logic                                                     matrix_ready,
  output logic [MATRIX_HEIGHT*RESULT_CELL_WIDTH-1:0]               result,
  output logic                                                     result_valid,
  input  logic                                                     result_ready,
  output logic                                                     error
);

  localparam int c_prod_w   = VECTOR_CELL_WIDTH + MATRIX_CELL_WIDTH;
  localparam int c_acc_base = c_prod_w + $clog2(MATRIX_WIDTH) + 1;
  localparam int c_acc_min  = RESULT_CELL_WIDTH + FRACTION_WIDTH + 1;
  localparam int c_acc_w    = (c_acc_base > c_acc_min) ? c_acc_base : c_acc_min;

  localparam int c_row_tiles = (MATRIX_HEIGHT + TILING_ROW - 1) / TILING_ROW;
  localparam int c_col_tiles = (MATRIX_WIDTH + TILING_COL - 1) / TILING_COL;
  localparam int c_rt_w      = (c_row_tiles > 1) ? $clog2(c_row_tiles) : 1;
  localparam int c_ct_w      = (c_col_tiles > 1) ? $clog2(c_col_tiles) : 1;

  localparam logic [c_rt_w-1:0] c_last_rt = c_rt_w'(c_row_tiles - 1);
  localparam logic [c_ct_w-1:0] c_last_ct = c_ct_w'(c_col_tiles - 1);

  localparam logic signed [c_acc_w-1:0] c_res_max = c_acc_w'((2 ** (RESULT_CELL_WIDTH - 1)) - 1);
  localparam logic signed [c_acc_w-1:0] c_res_min = -c_res_max - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [MATRIX_WIDTH*VECTOR_CELL_WIDTH-1:0]               r_vec;
  logic [MATRIX_WIDTH*MATRIX_HEIGHT*MATRIX_CELL_WIDTH-1:0] r_mat;
  logic                                                    r_vec_set;
  logic                                                    r_mat_set;
  logic [c_rt_w-1:0]                                       r_rt;
  logic [c_ct_w-1:0]                                       r_ct;
  logic signed [c_acc_w-1:0]                               r_acc      [MATRIX_HEIGHT];
  logic signed [c_acc_w-1:0]                               w_acc_next [MATRIX_HEIGHT];
  logic [MATRIX_HEIGHT*RESULT_CELL_WIDTH-1:0]              r_result;
  logic [MATRIX_HEIGHT*RESULT_CELL_WIDTH-1:0]              w_result;
  logic                                                    r_error;
  logic                                                    w_sat;
  logic                                                    w_vec_hs;
  logic                                                    w_mat_hs;
  logic                                                    w_last_tile;
  logic                                                    w_start;

  assign vector_ready = ~r_vec_set;
  assign matrix_ready = ~r_mat_set;
  assign w_vec_hs     = vector_valid & ~r_vec_set;
  assign w_mat_hs     = matrix_valid & ~r_mat_set;
  assign w_start      = (r_state == S_IDLE) & r_vec_set & r_mat_set;
  assign w_last_tile  = (r_state == S_CALC) & (r_rt == c_last_rt) & (r_ct == c_last_ct);

  assign result       = r_result;
  assign error        = r_error;
  assign result_valid = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (r_vec_set && r_mat_set) w_state_next = S_CALC;
      S_CALC:  if (w_last_tile) w_state_next = S_DONE;
      S_DONE:  if (result_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // One tile of TILING_ROW x TILING_COL products; out-of-range lanes are skipped.
  always_comb begin
    w_acc_next = r_acc;
    for (int i = 0; i < TILING_ROW; i++) begin
      for (int j = 0; j < TILING_COL; j++) begin
        int                         h;
        int                         w;
        logic signed [c_prod_w-1:0] p;
        h = int'(r_rt) * TILING_ROW + i;
        w = int'(r_ct) * TILING_COL + j;
        p = '0;
        if (h < MATRIX_HEIGHT && w < MATRIX_WIDTH) begin
          p = $signed(r_mat[(h*MATRIX_WIDTH+w)*MATRIX_CELL_WIDTH +: MATRIX_CELL_WIDTH])
            * $signed(r_vec[w*VECTOR_CELL_WIDTH +: VECTOR_CELL_WIDTH]);
          w_acc_next[h] = w_acc_next[h] + {{(c_acc_w-c_prod_w){p[c_prod_w-1]}}, p};
        end
      end
    end
  end

  // Drop fraction bits (floor) then clamp into the result cell range.
  always_comb begin
    w_result = '0;
    w_sat    = 1'b0;
    for (int h = 0; h < MATRIX_HEIGHT; h++) begin
      logic signed [c_acc_w-1:0] s;
      s = w_acc_next[h] >>> FRACTION_WIDTH;
      if (s > c_res_max) begin
        w_result[h*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] = c_res_max[RESULT_CELL_WIDTH-1:0];
        w_sat = 1'b1;
      end else if (s < c_res_min) begin
        w_result[h*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] = c_res_min[RESULT_CELL_WIDTH-1:0];
        w_sat = 1'b1;
      end else begin
        w_result[h*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] = s[RESULT_CELL_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vec     <= '0;
      r_mat     <= '0;
      r_vec_set <= 1'b0;
      r_mat_set <= 1'b0;
      r_rt      <= '0;
      r_ct      <= '0;
      r_result  <= '0;
      r_error   <= 1'b0;
      for (int h = 0; h < MATRIX_HEIGHT; h++) begin
        r_acc[h] <= '0;
      end
    end else begin
      if (w_vec_hs) begin
        r_vec     <= vector;
        r_vec_set <= 1'b1;
      end
      if (w_mat_hs) begin
        r_mat     <= matrix;
        r_mat_set <= 1'b1;
      end
      if (w_start) begin
        r_rt <= '0;
        r_ct <= '0;
        for (int h = 0; h < MATRIX_HEIGHT; h++) begin
          r_acc[h] <= '0;
        end
      end
      if (r_state == S_CALC) begin
        r_acc <= w_acc_next;
        if (r_ct == c_last_ct) begin
          r_ct <= '0;
          r_rt <= r_rt + 1'b1;
        end else begin
          r_ct <= r_ct + 1'b1;
        end
        if (w_last_tile) begin
          r_result <= w_result;
          r_error  <= w_sat;
        end
      end
      if (r_state == S_DONE && result_ready) begin
        r_vec_set <= 1'b0;
        r_mat_set <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mvm_transpose.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mvm_transpose: directed self-checking bench for mvm_transpose           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mvm_transpose;

  localparam int MW  = 4;
  localparam int MH  = 5;
  localparam int VCW = 8;
  localparam int MCW = 8;
  localparam int RCW = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [MW*VCW-1:0]       vector;
  logic                    vector_valid;
  logic                    vector_ready;
  logic [MW*MH*MCW-1:0]    matrix;
  logic                    matrix_valid;
  logic                    matrix_ready;
  logic [MH*RCW-1:0]       result;
  logic                    result_valid;
  logic                    result_ready;
  logic                    error;

  int n_cmp = 0;
  int n_err = 0;

  mvm_transpose #(
    .MATRIX_WIDTH      (MW),
    .MATRIX_HEIGHT     (MH),
    .VECTOR_CELL_WIDTH (VCW),
    .MATRIX_CELL_WIDTH (MCW),
    .RESULT_CELL_WIDTH (RCW),
    .FRACTION_WIDTH    (4),
    .TILING_ROW        (3),
    .TILING_COL        (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vector       (vector),
    .vector_valid (vector_valid),
    .vector_ready (vector_ready),
    .matrix       (matrix),
    .matrix_valid (matrix_valid),
    .matrix_ready (matrix_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW*MH*MCW-1:0] mat_fill(input int v);
    logic [MW*MH*MCW-1:0] m;
    for (int c = 0; c < MW*MH; c++) m[c*MCW +: MCW] = MCW'(v);
    return m;
  endfunction

  function automatic logic [MW*MH*MCW-1:0] mat_diag(input int v);
    logic [MW*MH*MCW-1:0] m;
    m = '0;
    for (int h = 0; h < MH; h++)
      for (int w = 0; w < MW; w++)
        if (h == w) m[(h*MW+w)*MCW +: MCW] = MCW'(v);
    return m;
  endfunction

  function automatic logic [MW*VCW-1:0] vec4(input int a, input int b, input int c, input int d);
    return {VCW'(d), VCW'(c), VCW'(b), VCW'(a)};
  endfunction

  function automatic logic [MH*RCW-1:0] res5(input int a, input int b, input int c,
                                             input int d, input int e);
    return {RCW'(e), RCW'(d), RCW'(c), RCW'(b), RCW'(a)};
  endfunction

  task automatic wait_result(output int k);
    k = 0;
    while (!result_valid && k < 40) begin
      step();
      k++;
    end
  endtask

  // Offer both operands together, then check latency, result and release.
  task automatic run_op(input string tag, input logic [MW*MH*MCW-1:0] m,
                        input logic [MW*VCW-1:0] v, input logic [MH*RCW-1:0] exp_res,
                        input logic exp_err);
    int lat;
    matrix       = m;
    vector       = v;
    matrix_valid = 1'b1;
    vector_valid = 1'b1;
    step();
    matrix_valid = 1'b0;
    vector_valid = 1'b0;
    chk({tag, "_busy_ready"}, {62'd0, vector_ready, matrix_ready}, 64'd0);
    wait_result(lat);
    chk({tag, "_latency"}, 64'(lat), 64'd5);
    chk({tag, "_result"}, 64'(result), 64'(exp_res));
    chk({tag, "_error"}, 64'(error), 64'(exp_err));
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk({tag, "_release"}, {61'd0, result_valid, vector_ready, matrix_ready}, 64'b011);
    chk({tag, "_hold"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    int lat;
    logic [MH*RCW-1:0] r80;
    logic [MH*RCW-1:0] rdiag;
    r80   = res5(80, 80, 80, 80, 80);
    rdiag = res5(16, 32, 48, 64, 0);

    rst          = 1'b0;
    vector       = '0;
    matrix       = '0;
    vector_valid = 1'b0;
    matrix_valid = 1'b0;
    result_ready = 1'b0;
    #1;
    chk("reset_ready", {62'd0, vector_ready, matrix_ready}, 64'b11);
    chk("reset_valid", 64'(result_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    step();
    step();
    rst = 1'b1;
    step();

    run_op("ones", mat_fill(16), vec4(16, 32, 48, -16), r80, 1'b0);
    run_op("diag", mat_diag(16), vec4(16, 32, 48, 64), rdiag, 1'b0);
    run_op("sat_pos", mat_fill(127), vec4(127, 127, 127, 127), res5(127, 127, 127, 127, 127), 1'b1);
    run_op("sat_neg", mat_fill(127), vec4(-128, -128, -128, -128),
           res5(-128, -128, -128, -128, -128), 1'b1);
    run_op("floor", mat_fill(1), vec4(-1, -1, -1, -1), res5(-1, -1, -1, -1, -1), 1'b0);
    run_op("edge", mat_diag(16), vec4(127, -128, -1, 0), res5(127, -128, -1, 0, 0), 1'b0);

    // Matrix first, a second matrix offer that must be ignored, vector last.
    matrix       = mat_fill(16);
    matrix_valid = 1'b1;
    step();
    matrix_valid = 1'b0;
    chk("order_mat_ready", {62'd0, vector_ready, matrix_ready}, 64'b10);
    step();
    matrix       = mat_diag(16);
    matrix_valid = 1'b1;
    step();
    matrix_valid = 1'b0;
    chk("order_wait", {62'd0, result_valid, matrix_ready}, 64'b00);
    vector       = vec4(16, 32, 48, -16);
    vector_valid = 1'b1;
    step();
    vector_valid = 1'b0;
    wait_result(lat);
    chk("order_latency", 64'(lat), 64'd5);
    chk("order_result", 64'(result), 64'(r80));
    for (int c = 0; c < 10; c++) begin
      step();
      chk("bp_flags", {61'd0, result_valid, vector_ready, matrix_ready}, 64'b100);
      chk("bp_result", 64'(result), 64'(r80));
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("bp_release", {61'd0, result_valid, vector_ready, matrix_ready}, 64'b011);

    // Asynchronous reset while tiles are being accumulated.
    matrix       = mat_fill(16);
    vector       = vec4(16, 32, 48, -16);
    matrix_valid = 1'b1;
    vector_valid = 1'b1;
    step();
    matrix_valid = 1'b0;
    vector_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("midrst_ready", {62'd0, vector_ready, matrix_ready}, 64'b11);
    chk("midrst_valid", 64'(result_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_error", 64'(error), 64'd0);
    step();
    rst = 1'b1;
    step();
    run_op("after_rst", mat_diag(16), vec4(16, 32, 48, 64), rdiag, 1'b0);

    // Back-to-back with the consumer always ready.
    result_ready = 1'b1;
    matrix       = mat_fill(16);
    vector       = vec4(16, 32, 48, -16);
    matrix_valid = 1'b1;
    vector_valid = 1'b1;
    step();
    matrix_valid = 1'b0;
    vector_valid = 1'b0;
    wait_result(lat);
    chk("b2b_a_latency", 64'(lat), 64'd5);
    chk("b2b_a_result", 64'(result), 64'(r80));
    step();
    chk("b2b_ready", {61'd0, result_valid, vector_ready, matrix_ready}, 64'b011);
    matrix       = mat_diag(16);
    vector       = vec4(16, 32, 48, 64);
    matrix_valid = 1'b1;
    vector_valid = 1'b1;
    step();
    matrix_valid = 1'b0;
    vector_valid = 1'b0;
    lat = 0;
    while (!result_valid && lat < 40) begin
      chk("b2b_a_held", 64'(result), 64'(r80));
      step();
      lat++;
    end
    chk("b2b_b_latency", 64'(lat), 64'd5);
    chk("b2b_b_result", 64'(result), 64'(rdiag));
    chk("b2b_b_error", 64'(error), 64'd0);
    step();
    result_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mvm_transpose.md
# mvm_transpose

Backward-pass matrix-vector multiplier: computes resultᵀ = matrixᵀ-style product, result[h] = Σ_w matrix[h][w]·vector[w], i.e. propagates a MATRIX_WIDTH-long error vector back through a MATRIX_WIDTH×MATRIX_HEIGHT weight matrix to produce a MATRIX_HEIGHT-long vector. It shares the matrix layout and valid/ready conventions of the forward mvm, so the same weight buffer feeds both. It sits in the backpropagation datapath between the output-layer delta computation and the hidden-layer delta logic. Arithmetic is signed fixed point with saturation and an overflow flag.

## Interface
- MATRIX_WIDTH, 4: columns of matrix; length of input vector
- MATRIX_HEIGHT, 5: rows of matrix; length of result
- VECTOR_CELL_WIDTH, 8: bits per vector cell, signed
- MATRIX_CELL_WIDTH, 8: bits per matrix cell, signed
- RESULT_CELL_WIDTH, 8: bits per result cell, signed
- FRACTION_WIDTH, 4: fraction bits of vector, matrix and result cells
- TILING_ROW, 3: result rows processed per cycle
- TILING_COL, 3: vector cells (columns) processed per cycle
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- vector  input  MATRIX_WIDTH*VECTOR_CELL_WIDTH  cell w at bits [w*VCW +: VCW]
- vector_valid  input  1  vector offered
- vector_ready  output  1  vector buffer empty
- matrix  input  MATRIX_WIDTH*MATRIX_HEIGHT*MATRIX_CELL_WIDTH  cell (h,w) at [(h*MATRIX_WIDTH+w)*MCW +: MCW]
- matrix_valid  input  1  matrix offered
- matrix_ready  output  1  matrix buffer empty
- result  output  MATRIX_HEIGHT*RESULT_CELL_WIDTH  cell h at [h*RCW +: RCW]
- result_valid  output  1  result available
- result_ready  input  1  consumer accepts result
- error  output  1  at least one result cell saturated; qualified by result_valid

## Operation
- States IDLE, CALC, DONE. Reset: IDLE, buffers/flags/accumulators 0, result 0, error 0, result_valid 0, vector_ready 1, matrix_ready 1.
- vector_ready = !vector_set, matrix_ready = !matrix_set. Handshake = valid && ready; captures data and sets flag. Vector and matrix accepted independently, any order, same cycle allowed.
- IDLE: when both flags set at a clock edge, go CALC, clear accumulators and tile counters.
- CALC: tile counter pair (h0, w0); w0 inner loop stepping by TILING_COL from 0, h0 outer stepping by TILING_ROW. Each cycle adds TILING_ROW×TILING_COL products M[h0+i][w0+j]·v[w0+j] into accumulator h0+i; lanes with h ≥ MATRIX_HEIGHT or w ≥ MATRIX_WIDTH contribute 0 and write nothing.
- N = ceil(MATRIX_HEIGHT/TILING_ROW)·ceil(MATRIX_WIDTH/TILING_COL) CALC cycles (default 4). On the edge processing the last tile: go DONE, write result and error.
- Arithmetic: products full precision; accumulators ≥ VCW+MCW+clog2(MATRIX_WIDTH)+1 bits, no internal overflow. Final cell = acc >>> FRACTION_WIDTH (arithmetic shift, truncation toward −∞), saturated to [−2^(RCW−1), 2^(RCW−1)−1]; error = OR of per-cell saturation.
- DONE: result_valid 1; result, error stable. On result_ready: go IDLE, clear both set flags (ready rises next cycle). result/error hold last value in IDLE until next DONE.
- valid during CALC/DONE ignored (ready low). A second valid on an already-set input in IDLE ignored.
- rst low at any time: immediate return to reset values; in-progress computation discarded.

## Timing
- Last input handshake at edge 0 → CALC at edge 1 → tiles at edges 2..N+1 → result_valid high after edge N+1: latency N+1 cycles (5 default).
- Result handshake at edge k → result_valid low, vector_ready/matrix_ready high after edge k; earliest new input capture edge k+1.
- Throughput: one product per N+3 cycles minimum.
- No combinational path from any valid to any ready; result_valid depends only on state.

## Test plan
- Defaults, all matrix cells 16 (1.0), vector [16,32,48,−16] → after 5 cycles result_valid, every one of 5 result cells = 80, error 0.
- Orientation: M[h][w]=16 iff h==w else 0, vector [16,32,48,64] → result [16,32,48,64,0], error 0.
- Saturation: all matrix 127, vector 127 → all cells 127, error 1; vector −128 → all cells −128, error 1.
- Ordering/backpressure: matrix at cycle 0, vector at cycle 3, matrix_valid re-asserted with other data at cycle 2 (ignored); result_ready low 10 cycles → result and valid held stable, both readies low; then ready 1 → readies high next cycle.
- Reset mid-CALC: rst low at edge 3 of CALC → outputs at reset values immediately; fresh operation afterwards produces correct result with no residue.
- Back-to-back: two operations with result_ready tied 1 → second result correct, first result unchanged until second DONE.
